// File: rtl/spec_add_pkg.sv
// Shared definitions for the carry-speculative adder stage: FSM states,
// default geometry and the boundary-count helper.
package spec_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      FIX,
      HOLD
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_BLOCK = 4;

   function automatic int num_boundaries(input int width, input int block);
      return width / block - 1;
   endfunction

endpackage

// File: rtl/spec_block_adder.sv
// Plain BLOCK-bit ripple adder used as one segment of the speculative sum.
module spec_block_adder
   import spec_add_pkg::*;
#(
   parameter int BLOCK = DEF_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, cin};

endmodule

// File: rtl/spec_add_recovery.sv
// Variable-latency carry-speculative adder: 1-cycle speculative result, or an
// extra FIX cycle producing the exact sum when any block boundary mispredicts.
module spec_add_recovery
   import spec_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int BLOCK = DEF_BLOCK,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             corrected,
   output logic [CNT_W-1:0] err_count
);

   localparam int NBLK = num_boundaries(WIDTH, BLOCK) + 1;

   state_t state_q, state_d;

   logic [WIDTH-1:0] ra, rb;
   logic             rcin;

   logic [NBLK-1:0]  spec_ci;
   logic [NBLK-1:0]  spec_co;
   logic [NBLK-1:0]  mism;
   logic [WIDTH-1:0] spec_sum;
   logic [WIDTH:0]   exact;
   logic             err;

   logic accept, ld_spec, ld_fix, inc_err, drain;

   // Speculative path: each block guesses its carry-in from the generate of
   // the bit just below its boundary.
   for (genvar i = 0; i < NBLK; i++) begin : g_blk
      if (i == 0) begin : g_first
         assign spec_ci[i] = rcin;
      end else begin : g_rest
         assign spec_ci[i] = ra[BLOCK*i-1] & rb[BLOCK*i-1];
      end
      spec_block_adder #(.BLOCK(BLOCK)) u_blk (
         .a    (ra[BLOCK*i +: BLOCK]),
         .b    (rb[BLOCK*i +: BLOCK]),
         .cin  (spec_ci[i]),
         .sum  (spec_sum[BLOCK*i +: BLOCK]),
         .cout (spec_co[i])
      );
   end

   // True carry into each boundary from the exact sum of the bits below it.
   assign mism[0] = 1'b0;
   for (genvar k = 1; k < NBLK; k++) begin : g_bnd
      logic [BLOCK*k:0] part;
      assign part    = {1'b0, ra[BLOCK*k-1:0]} + {1'b0, rb[BLOCK*k-1:0]}
                     + {{(BLOCK*k){1'b0}}, rcin};
      assign mism[k] = spec_ci[k] ^ part[BLOCK*k];
   end

   assign err   = |mism;
   assign exact = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rcin};

   assign in_ready = (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      ld_spec = 1'b0;
      ld_fix  = 1'b0;
      inc_err = 1'b0;
      drain   = 1'b0;
      case (state_q)
         IDLE: if (in_valid) begin
            accept  = 1'b1;
            state_d = EVAL;
         end
         EVAL: if (err) begin
            inc_err = 1'b1;
            state_d = FIX;
         end else begin
            ld_spec = 1'b1;
            state_d = HOLD;
         end
         FIX: begin
            ld_fix  = 1'b1;
            state_d = HOLD;
         end
         HOLD: if (out_ready) begin
            drain   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ra        <= '0;
         rb        <= '0;
         rcin      <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         corrected <= 1'b0;
         err_count <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ra   <= a;
            rb   <= b;
            rcin <= cin;
         end
         if (ld_spec) begin
            sum       <= spec_sum;
            cout      <= spec_co[NBLK-1];
            corrected <= 1'b0;
            out_valid <= 1'b1;
         end else if (ld_fix) begin
            sum       <= exact[WIDTH-1:0];
            cout      <= exact[WIDTH];
            corrected <= 1'b1;
            out_valid <= 1'b1;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
         if (inc_err && err_count != '1)
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_spec_add_recovery.sv
// Scoreboard bench for spec_add_recovery (16-bit, 4-bit blocks, 2-bit counter).
module tb_spec_add_recovery;

   localparam int W  = 16;
   localparam int BL = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic          cin;
   logic          out_valid, out_ready;
   logic [W-1:0]  sum;
   logic          cout, corrected;
   logic [CW-1:0] err_count;

   spec_add_recovery #(.WIDTH(W), .BLOCK(BL), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .corrected (corrected),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]  s;
      logic          c;
      logic          corr;
      int            lat;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [CW-1:0] cnt_model = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: boundary k mispredicts when the bit-(4k-1) generate differs
   // from the carry produced by adding the low 4k bits exactly.
   function automatic logic model_err(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      logic [31:0] lo;
      logic        spec, tru;
      model_err = 1'b0;
      for (int k = 1; k < W / BL; k++) begin
         lo   = ({16'h0, x} & ((32'h1 << (BL * k)) - 1)) + ({16'h0, y} & ((32'h1 << (BL * k)) - 1)) + {31'h0, ci};
         tru  = lo[BL * k];
         spec = x[BL * k - 1] & y[BL * k - 1];
         if (spec != tru) model_err = 1'b1;
      end
   endfunction

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input int hold, input string tag);
      exp_t        e, g;
      logic [16:0] full;
      logic        er;
      int          lat;
      full = {1'b0, x} + {1'b0, y} + {16'h0, ci};
      er   = model_err(x, y, ci);
      if (er && cnt_model != '1) cnt_model = cnt_model + 1'b1;
      e.s = full[W-1:0]; e.c = full[W]; e.corr = er; e.lat = er ? 2 : 1; e.cnt = cnt_model;

      @(negedge clk);
      a = x; b = y; cin = ci; in_valid = 1'b1;
      check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      sb.push_back(e);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1 lat++;
      end
      g = sb.pop_front();
      check({tag, "_latency"},   lat,                   g.lat);
      check({tag, "_sum"},       {16'h0, sum},          {16'h0, g.s});
      check({tag, "_cout"},      {31'h0, cout},         {31'h0, g.c});
      check({tag, "_corrected"}, {31'h0, corrected},    {31'h0, g.corr});
      check({tag, "_err_count"}, {30'h0, err_count},    {30'h0, g.cnt});

      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
         check({tag, "_hold_sum"},   {15'h0, cout, sum}, {15'h0, g.c, g.s});
         check({tag, "_hold_corr"},  {31'h0, corrected}, {31'h0, g.corr});
         check({tag, "_hold_ready"}, {31'h0, in_ready},  32'h0);
      end

      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_drain_valid"}, {31'h0, out_valid}, 32'h0);
      check({tag, "_drain_ready"}, {31'h0, in_ready},  32'h1);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'h0, in_ready},  32'h1);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_sum",       {16'h0, sum},       32'h0);
      check("rst_cout",      {31'h0, cout},      32'h0);
      check("rst_corrected", {31'h0, corrected}, 32'h0);
      check("rst_err_count", {30'h0, err_count}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      do_op(16'h0001, 16'h0002, 1'b0, 0, "clean");
      do_op(16'h000F, 16'h0001, 1'b0, 0, "fix_lo");
      do_op(16'h0008, 16'h0008, 1'b0, 0, "gen_ok");
      do_op(16'hFFFF, 16'h0001, 1'b0, 5, "wrap_hold");
      do_op(16'h1234, 16'h4321, 1'b1, 1, "cin_clean");
      for (int i = 0; i < 8; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), i % 3, "rand");

      // Reset while the erroring op sits in FIX.
      @(negedge clk);
      a = 16'h000F; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rstfix_out_valid", {31'h0, out_valid}, 32'h0);
      check("rstfix_in_ready",  {31'h0, in_ready},  32'h1);
      check("rstfix_err_count", {30'h0, err_count}, 32'h0);
      check("rstfix_corrected", {31'h0, corrected}, 32'h0);
      cnt_model = '0;
      @(negedge clk);
      rst = 1'b0;
      do_op(16'h0001, 16'h0002, 1'b0, 0, "post_rst");

      for (int i = 0; i < 5; i++)
         do_op(16'h000F, 16'h0001, 1'b0, 0, "sat");

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
